unified_mem_arbiter: RTL and testbench

- Single-port memory front end for the pipelined RV32 core.
- Arbitrates the IF-stage instruction fetch port and the MEM-stage data port onto one shared memory.
- Handles byte-lane generation for SB/SH/SW and sign/zero extension for LB/LH/LW/LBU/LHU from funct3.
- Lets the core use one combined instruction/data memory; the pipeline stalls on its client port until that port is granted and its response returns.

---
 rtl/unified_mem_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shared instruction/data memory front end with RV32 lane handling
// Optional ARB_ROUND_ROBIN_EN: alternate grants under contention instead of data priority.
module unified_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [2:0]        d_funct3,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  logic [1:0]       r_state;
  logic             r_owner;
  logic [1:0]       r_lane;
  logic [2:0]       r_funct3;
  logic             r_store;
  logic [CNT_W-1:0] r_wait;

  logic              w_idle;
  logic              w_pick_data;
  logic              w_grant;
  logic [ADDR_W-1:0] w_addr;
  logic [2:0]        w_f3;
  logic              w_we;
  logic              w_fault;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [15:0]       w_lane_word;
  logic [31:0]       w_load;

  assign w_idle = (r_state == S_IDLE) & ~rst;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_owner;
  assign w_pick_data = d_req & ~(i_req & r_last_owner);
`else
  assign w_pick_data = d_req;
`endif

  assign d_gnt   = w_idle & w_pick_data;
  assign i_gnt   = w_idle & i_req & ~w_pick_data;
  assign w_grant = d_gnt | i_gnt;

  // Fetches look like aligned word loads to the shared checks below.
  assign w_addr = w_pick_data ? d_addr : i_addr;
  assign w_f3   = w_pick_data ? d_funct3 : 3'b010;
  assign w_we   = w_pick_data & d_we;

  always_comb begin
    w_fault = 1'b0;
    case (w_f3)
      3'b000:         w_fault = 1'b0;
      3'b001:         w_fault = w_addr[0];
      3'b010:         w_fault = |w_addr[1:0];
      3'b100, 3'b101: w_fault = w_we;
      default:        w_fault = 1'b1;
    endcase
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = d_wdata;
    case (w_f3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_addr[1:0];
        w_wdata = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << w_addr[1:0];
        w_wdata = {2{d_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!w_we) w_wdata = '0;
  end

  assign w_lane_word = 16'(mem_rdata >> {r_lane, 3'b000});

  always_comb begin
    w_load = mem_rdata;
    if (r_store) begin
      w_load = '0;
    end else begin
      case (r_funct3)
        3'b000:  w_load = {{24{w_lane_word[7]}}, w_lane_word[7:0]};
        3'b001:  w_load = {{16{w_lane_word[15]}}, w_lane_word};
        3'b100:  w_load = {24'd0, w_lane_word[7:0]};
        3'b101:  w_load = {16'd0, w_lane_word};
        default: w_load = mem_rdata;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_lane    <= '0;
      r_funct3  <= '0;
      r_store   <= 1'b0;
      r_wait    <= '0;
      i_rvalid  <= 1'b0;
      i_rdata   <= '0;
      i_err     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_owner <= 1'b0;
`endif
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_owner  <= w_pick_data;
            r_lane   <= w_addr[1:0];
            r_funct3 <= w_f3;
            r_store  <= w_we;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_owner <= w_pick_data;
`endif
            if (w_fault) begin
              r_state <= S_RESP;
              if (w_pick_data) begin
                d_rvalid <= 1'b1;
                d_err    <= 1'b1;
              end else begin
                i_rvalid <= 1'b1;
                i_err    <= 1'b1;
              end
            end else begin
              r_state   <= S_ACCESS;
              r_wait    <= '0;
              mem_req   <= 1'b1;
              mem_we    <= w_we;
              mem_addr  <= {w_addr[ADDR_W-1:2], 2'b00};
              mem_be    <= w_be;
              mem_wdata <= w_wdata;
            end
          end
        end
        S_ACCESS: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            r_state <= S_RESP;
            if (r_owner) begin
              d_rvalid <= 1'b1;
              d_rdata  <= w_load;
            end else begin
              i_rvalid <= 1'b1;
              i_rdata  <= mem_rdata;
            end
          end else if (r_wait == WAIT_LAST) begin
            mem_req <= 1'b0;
            r_state <= S_RESP;
            if (r_owner) begin
              d_rvalid <= 1'b1;
              d_err    <= 1'b1;
            end else begin
              i_rvalid <= 1'b1;
              i_err    <= 1'b1;
            end
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          i_rdata <= '0;
          i_err   <= 1'b0;
          d_rdata <= '0;
          d_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed bench with a transaction-level timing and data model
module tb_unified_mem_arbiter;

  localparam int MW = 4;
  localparam int NC = 600;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_gnt, i_rvalid, i_err;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [2:0]  d_funct3 = '0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_W(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_funct3(d_funct3), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit m_last = 1'b0;

  bit          exp_ig[NC], exp_dg[NC], exp_mreq[NC], exp_mwe[NC], exp_chkwd[NC];
  bit          exp_iv[NC], exp_dv[NC], exp_err[NC];
  logic [31:0] exp_ma[NC], exp_mwd[NC], exp_rd[NC];
  logic [3:0]  exp_be[NC];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string n, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h, expected %h", n, cyc, got, want);
    end
  endfunction

  function automatic bit model_fault(bit dport, bit we, logic [31:0] addr, logic [2:0] f3);
    if (!dport) return (addr % 4) != 0;
    case (f3)
      3'b000:         return 1'b0;
      3'b001:         return (addr % 2) != 0;
      3'b010:         return (addr % 4) != 0;
      3'b100, 3'b101: return we;
      default:        return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] word, logic [31:0] addr, logic [2:0] f3);
    int unsigned sh, b, h;
    sh = 8 * (addr % 4);
    b = (word >> sh) % 256;
    h = (word >> sh) % 65536;
    case (f3)
      3'b000:  return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] model_be(bit dport, logic [31:0] addr, logic [2:0] f3);
    int sh;
    sh = int'(addr % 4);
    if (!dport || f3[1:0] == 2'b10) return 4'b1111;
    if (f3[1:0] == 2'b00) return 4'(1 << sh);
    return 4'(3 << sh);
  endfunction

  function automatic logic [31:0] model_wd(logic [31:0] wd, logic [2:0] f3);
    if (f3[1:0] == 2'b00) return (wd % 256) * 32'h01010101;
    if (f3[1:0] == 2'b01) return (wd % 65536) * 32'h00010001;
    return wd;
  endfunction

  // Fill the expected per-cycle picture of one transaction granted in cycle g.
  task automatic plan(bit dport, bit we, logic [31:0] addr, logic [31:0] wd, logic [2:0] f3,
                      logic [31:0] word, int w, int g);
    bit flt;
    int lat;
    int r;
    flt = model_fault(dport, we, addr, f3);
    if (dport) exp_dg[g] = 1'b1; else exp_ig[g] = 1'b1;
    m_last = dport;
    if (flt) begin
      r = g + 1;
    end else begin
      lat = (w < MW) ? w + 1 : MW;
      for (int k = 1; k <= lat; k++) begin
        exp_mreq[g+k]  = 1'b1;
        exp_ma[g+k]    = addr & 32'hFFFF_FFFC;
        exp_be[g+k]    = model_be(dport, addr, f3);
        exp_mwe[g+k]   = dport & we;
        exp_chkwd[g+k] = dport & we;
        exp_mwd[g+k]   = model_wd(wd, f3);
      end
      r = g + 1 + lat;
    end
    if (dport) exp_dv[r] = 1'b1; else exp_iv[r] = 1'b1;
    exp_err[r] = flt || (w >= MW);
    exp_rd[r]  = exp_err[r] ? 32'd0 : (!dport ? word : (we ? 32'd0 : model_load(word, addr, f3)));
  endtask

  task automatic clear_from(int c);
    for (int k = c; k < NC; k++) begin
      exp_ig[k] = 0; exp_dg[k] = 0; exp_mreq[k] = 0; exp_mwe[k] = 0; exp_chkwd[k] = 0;
      exp_iv[k] = 0; exp_dv[k] = 0; exp_err[k] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < NC) begin
      chk("i_gnt", i_gnt, exp_ig[cyc]);
      chk("d_gnt", d_gnt, exp_dg[cyc]);
      chk("mem_req", mem_req, exp_mreq[cyc]);
      chk("i_rvalid", i_rvalid, exp_iv[cyc]);
      chk("d_rvalid", d_rvalid, exp_dv[cyc]);
      if (exp_mreq[cyc]) begin
        chk("mem_addr", mem_addr, exp_ma[cyc]);
        chk("mem_be", mem_be, exp_be[cyc]);
        chk("mem_we", mem_we, exp_mwe[cyc]);
        if (exp_chkwd[cyc]) chk("mem_wdata", mem_wdata, exp_mwd[cyc]);
      end
      if (exp_iv[cyc]) begin
        chk("i_rdata", i_rdata, exp_rd[cyc]);
        chk("i_err", i_err, exp_err[cyc]);
      end
      if (exp_dv[cyc]) begin
        chk("d_rdata", d_rdata, exp_rd[cyc]);
        chk("d_err", d_err, exp_err[cyc]);
      end
    end
  end

  // One request with memory answering after w wait cycles, plus hand-computed literals.
  task automatic do_txn(string nm, bit dport, bit we, logic [31:0] addr, logic [31:0] wd,
                        logic [2:0] f3, logic [31:0] word, int w, logic [31:0] lit_rd,
                        bit lit_err, logic [3:0] lit_be, logic [31:0] lit_wd);
    int g;
    bit flt;
    int lat;
    g = cyc;
    flt = model_fault(dport, we, addr, f3);
    lat = (w < MW) ? w + 1 : MW;
    plan(dport, we, addr, wd, f3, word, w, g);
    mem_rdata = word;
    if (dport) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd; d_funct3 = f3;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    @(posedge clk); #1;
    i_req = 1'b0;
    d_req = 1'b0;
    if (!flt) begin
      chk({nm, "_be"}, mem_be, lit_be);
      if (dport && we) chk({nm, "_wdata"}, mem_wdata, lit_wd);
      for (int k = 1; k <= lat; k++) begin
        mem_ready = (k == w + 1);
        @(posedge clk); #1;
        mem_ready = 1'b0;
      end
    end
    chk({nm, "_rvalid"}, dport ? d_rvalid : i_rvalid, 1);
    chk({nm, "_rdata"}, dport ? d_rdata : i_rdata, lit_rd);
    chk({nm, "_err"}, dport ? d_err : i_err, lit_err);
    @(posedge clk); #1;
  endtask

  task automatic contention();
    int g;
    bit f;
    g = cyc;
`ifdef ARB_ROUND_ROBIN_EN
    f = (m_last == 1'b0);
`else
    f = 1'b1;
`endif
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30; d_funct3 = 3'b010; d_wdata = '0;
    i_req = 1'b1; i_addr = 32'h14;
    if (f) begin
      plan(1, 0, 32'h30, 0, 3'b010, 32'hCAFEF00D, 0, g);
      plan(0, 0, 32'h14, 0, 3'b010, 32'h00A00113, 0, g + 3);
    end else begin
      plan(0, 0, 32'h14, 0, 3'b010, 32'h00A00113, 0, g);
      plan(1, 0, 32'h30, 0, 3'b010, 32'hCAFEF00D, 0, g + 3);
    end
    #1;
    chk("cont_first_d_gnt", d_gnt, f);
    chk("cont_first_i_gnt", i_gnt, !f);
    @(posedge clk); #1;
    if (f) d_req = 1'b0; else i_req = 1'b0;
    mem_rdata = f ? 32'hCAFEF00D : 32'h00A00113;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("cont_second_d_gnt", d_gnt, !f);
    chk("cont_second_i_gnt", i_gnt, f);
    @(posedge clk); #1;
    if (f) i_req = 1'b0; else d_req = 1'b0;
    mem_rdata = f ? 32'h00A00113 : 32'hCAFEF00D;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic reset_mid_access();
    int g;
    g = cyc;
    plan(1, 0, 32'h60, 0, 3'b010, 32'h11111111, 100, g);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60; d_funct3 = 3'b010;
    @(posedge clk); #1;
    d_req = 1'b0;
    chk("rst_pre_mem_req", mem_req, 1);
    @(posedge clk); #1;
    clear_from(g + 2);
    rst = 1'b1;
    #1;
    chk("rst_async_mem_req", mem_req, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_last = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mem_req", mem_req, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_be", mem_be, 0);
    chk("reset_i_rvalid", i_rvalid, 0);
    chk("reset_d_rvalid", d_rvalid, 0);
    chk("reset_i_rdata", i_rdata, 0);
    chk("reset_d_rdata", d_rdata, 0);
    chk("reset_d_err", d_err, 0);
    chk("reset_i_err", i_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_txn("fetch",   0, 0, 32'h10, 0, 3'b010, 32'h00500093, 0, 32'h00500093, 0, 4'b1111, 0);
    do_txn("lb",      1, 0, 32'h23, 0, 3'b000, 32'h80FF7F01, 0, 32'hFFFFFF80, 0, 4'b1000, 0);
    do_txn("lbu",     1, 0, 32'h23, 0, 3'b100, 32'h80FF7F01, 0, 32'h00000080, 0, 4'b1000, 0);
    do_txn("lh",      1, 0, 32'h22, 0, 3'b001, 32'h80FF7F01, 0, 32'hFFFF80FF, 0, 4'b1100, 0);
    do_txn("lhu",     1, 0, 32'h22, 0, 3'b101, 32'h80FF7F01, 1, 32'h000080FF, 0, 4'b1100, 0);
    do_txn("lw",      1, 0, 32'h20, 0, 3'b010, 32'h80FF7F01, 2, 32'h80FF7F01, 0, 4'b1111, 0);
    do_txn("lb_wait3",1, 0, 32'h51, 0, 3'b000, 32'h00007F00, 3, 32'h0000007F, 0, 4'b0010, 0);
    do_txn("sh",      1, 1, 32'h42, 32'h1234ABCD, 3'b001, 0, 0, 0, 0, 4'b1100, 32'hABCDABCD);
    do_txn("sb",      1, 1, 32'h41, 32'h000000A5, 3'b000, 0, 0, 0, 0, 4'b0010, 32'hA5A5A5A5);
    do_txn("sw",      1, 1, 32'h44, 32'hDEADBEEF, 3'b010, 0, 1, 0, 0, 4'b1111, 32'hDEADBEEF);
    do_txn("lw_mis",  1, 0, 32'h41, 0, 3'b010, 32'h12345678, 0, 0, 1, 4'b0000, 0);
    do_txn("if_mis",  0, 0, 32'h12, 0, 3'b010, 32'h12345678, 0, 0, 1, 4'b0000, 0);
    do_txn("sh_mis",  1, 1, 32'h43, 32'h5555, 3'b001, 0, 0, 0, 1, 4'b0000, 0);
    do_txn("ld_f3bad",1, 0, 32'h48, 0, 3'b011, 32'h12345678, 0, 0, 1, 4'b0000, 0);
    do_txn("st_f3bad",1, 1, 32'h48, 32'h77, 3'b100, 0, 0, 0, 1, 4'b0000, 0);
    do_txn("timeout", 1, 0, 32'h50, 0, 3'b010, 32'h12345678, 10, 0, 1, 4'b1111, 0);
    do_txn("if_tmo",  0, 0, 32'h58, 0, 3'b010, 32'h12345678, MW, 0, 1, 4'b1111, 0);

    reset_mid_access();
    do_txn("fetch_after_rst", 0, 0, 32'h14, 0, 3'b010, 32'h00A00113, 0, 32'h00A00113, 0, 4'b1111, 0);

    do_txn("sw_pre_cont", 1, 1, 32'h70, 32'h01020304, 3'b010, 0, 0, 0, 0, 4'b1111, 32'h01020304);
    contention();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
